// File: rtl/spi_boot_responder.sv
// rtl/spi_boot_responder.sv - SPI mode-0 read-only serial EEPROM emulator for DSP boot
//
// Answers READ (CMD_READ) + ADDR_W-bit address by streaming bytes from a
// byte-wide boot image store, auto-incrementing the address (wraps to 0).
// The SPI pins are oversampled by clk_in; nothing is clocked by sclk.
// Optional feature macro: RDSR_EN (accept opcode 0x05, read status = 0x00).
//
// Ports:
//   clk_in    system clock, >= 8x SCLK
//   rst_in    synchronous, active-high reset
//   sclk      SPI clock from DSP (idle low)
//   mosi      SPI data from DSP, MSB first
//   cs        SPI chip select, active low
//   miso      SPI data to DSP, MSB first
//   miso_oe   miso drive enable
//   mem_addr  boot image byte address
//   mem_rd    one-cycle read strobe, mem_data valid the following cycle
//   mem_data  boot image byte
//   busy      high while synchronized cs is low
//   cmd_err   one-cycle pulse on an unsupported opcode
module spi_boot_responder #(
  parameter int         ADDR_W      = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_READ    = 8'h03
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              cmd_err
);

  localparam int CNT_W = $clog2(ADDR_W + 1);
  localparam logic [CNT_W-1:0] LAST_ADDR_BIT = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] LAST_BYTE_BIT = CNT_W'(7);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd4;
  localparam logic [2:0] ST_STAT   = 3'd5;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, flush;
  logic sclk_s, mosi_s, cs_s;
  logic sclk_d, cs_d, armed;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [2:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [6:0]        cmd_sr;
  logic [ADDR_W-2:0] addr_sr;
  logic [7:0]        tx_sr;
  logic              load_pend;
  logic [7:0]        opcode_next;
  logic [ADDR_W-1:0] addr_next;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // sclk edges only count while cs is low, so an edge coinciding with the
  // cs rise is dropped. A cs fall only counts once cs has genuinely been
  // seen high after reset (armed), so a cs held low through reset does not
  // start a frame when the synchronizer drains its reset value.
  assign sclk_rise = ~sclk_d & sclk_s & ~cs_s;
  assign sclk_fall = sclk_d & ~sclk_s & ~cs_s;
  assign cs_fall   = armed & cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;

  assign opcode_next = {cmd_sr, mosi_s};
  assign addr_next   = {addr_sr, mosi_s};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      flush     <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      // flush marks when every synchronizer stage holds a real pin sample
      flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      if (flush[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      addr_sr   <= '0;
      tx_sr     <= '0;
      load_pend <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      busy      <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      mem_rd    <= 1'b0;
      cmd_err   <= 1'b0;
      load_pend <= mem_rd;
      busy      <= ~cs_s;
      if (cs_rise) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              cmd_sr  <= opcode_next[6:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BYTE_BIT) begin
                bit_cnt <= '0;
                if (opcode_next == CMD_READ) begin
                  state <= ST_ADDR;
`ifdef RDSR_EN
                end else if (opcode_next == 8'h05) begin
                  state   <= ST_STAT;
                  miso    <= 1'b0;
                  miso_oe <= 1'b1;
`endif
                end else begin
                  state   <= ST_IGNORE;
                  cmd_err <= 1'b1;
                end
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise) begin
              addr_sr <= addr_next[ADDR_W-2:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_ADDR_BIT) begin
                bit_cnt  <= '0;
                mem_addr <= addr_next;
                mem_rd   <= 1'b1;
                miso_oe  <= 1'b1;
                state    <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            // The fetched byte lands well before the next sclk fall because
            // clk_in runs at least 8x SCLK.
            if (load_pend) begin
              tx_sr <= mem_data;
            end else if (sclk_fall) begin
              miso  <= tx_sr[7];
              tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (sclk_rise) begin
              if (bit_cnt == LAST_BYTE_BIT) begin
                bit_cnt  <= '0;
                mem_addr <= mem_addr + 1'b1;
                mem_rd   <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_IGNORE: begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
          end
          ST_STAT: begin
            // Status byte is all zeros (WIP=0), repeated until cs rises.
            miso <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_boot_responder.sv
// tb/tb_spi_boot_responder.sv - scoreboard bench for spi_boot_responder
module tb_spi_boot_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        sclk   = 1'b0;
  logic        mosi   = 1'b0;
  logic        cs     = 1'b0;
  logic        miso, miso_oe, mem_rd, busy, cmd_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] exp_addr_q[$];
  logic [7:0]  exp_byte_q[$];
  int   extra_rd    = 0;
  int   extra_bytes = 0;
  int   cmd_err_cnt = 0;
  bit   oe_seen     = 1'b0;
  bit   rx_en       = 1'b0;
  int   rx_cnt      = 0;
  logic [7:0] rx_sr = 8'h00;

  always #5 clk_in = ~clk_in;

  spi_boot_responder dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sclk     (sclk),
    .mosi     (mosi),
    .cs       (cs),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  // Boot image model: byte = addr[7:0] ^ 0xA5, one cycle after mem_rd
  always @(posedge clk_in) if (mem_rd) mem_data <= mem_addr[7:0] ^ 8'hA5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory-side monitor
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (mem_rd === 1'b1) begin
        if (exp_addr_q.size() == 0) extra_rd++;
        else check("mem_rd_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (cmd_err === 1'b1) cmd_err_cnt++;
      if (miso_oe === 1'b1) oe_seen = 1'b1;
    end
  end

  // SPI-side monitor: master samples miso on sclk rise
  always @(posedge sclk) begin
    if (rx_en) begin
      rx_sr = {rx_sr[6:0], miso};
      rx_cnt++;
      if (rx_cnt == 8) begin
        rx_cnt = 0;
        if (exp_byte_q.size() == 0) extra_bytes++;
        else check("miso_byte", 32'(rx_sr), 32'(exp_byte_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic spi_bit(input logic b);
    mosi = b;
    repeat (4) @(posedge clk_in);
    #1 sclk = 1'b1;
    repeat (8) @(posedge clk_in);
    #1 sclk = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    repeat (8) @(posedge clk_in);
    #1;
  endtask

  task automatic cs_high();
    cs = 1'b1;
    repeat (8) @(posedge clk_in);
    #1;
  endtask

  task automatic clear_mon();
    cmd_err_cnt = 0;
    oe_seen     = 1'b0;
    rx_cnt      = 0;
  endtask

  task automatic read_txn(input logic [15:0] addr, input int nbytes);
    logic [15:0] a;
    a = addr;
    for (int i = 0; i <= nbytes; i++) begin
      exp_addr_q.push_back(a);
      if (i < nbytes) exp_byte_q.push_back(a[7:0] ^ 8'hA5);
      a = a + 16'd1;
    end
    cs_low();
    spi_byte(8'h03);
    spi_byte(addr[15:8]);
    spi_byte(addr[7:0]);
    rx_en = 1'b1;
    for (int i = 0; i < nbytes; i++) spi_byte(8'h00);
    rx_en = 1'b0;
    cs_high();
  endtask

  initial begin
    // 1: reset held while cs low and sclk toggling
    rst_in = 1'b1;
    cs     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in);
      #1 sclk = ~sclk;
      @(negedge clk_in);
      check("rst_ctrl", 32'({miso, miso_oe, mem_rd, busy, cmd_err}), 32'h0);
      check("rst_mem_addr", 32'(mem_addr), 32'h0);
    end
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    sclk = 1'b0;
    // cs still low from before reset: must not start a frame
    clear_mon();
    for (int i = 0; i < 10; i++) spi_bit(1'b1);
    check("post_rst_cmd_err", 32'(cmd_err_cnt), 32'd0);
    check("post_rst_oe", 32'(oe_seen), 32'd0);
    check("post_rst_rd", 32'(extra_rd), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd1);
    cs_high();
    check("idle_busy", 32'(busy), 32'd0);

    // 2: READ 0x0010, 3 bytes -> B5 B4 B7, reads 0x10..0x13
    clear_mon();
    read_txn(16'h0010, 3);
    check("t2_addr_q", 32'(exp_addr_q.size()), 32'd0);
    check("t2_byte_q", 32'(exp_byte_q.size()), 32'd0);
    check("t2_mem_addr", 32'(mem_addr), 32'h0013);
    check("t2_oe_seen", 32'(oe_seen), 32'd1);
    check("t2_cmd_err", 32'(cmd_err_cnt), 32'd0);
    check("t2_after_cs", 32'({miso, miso_oe}), 32'h0);

    // 3: READ 0xFFFF, 2 bytes -> 5A A5, address wraps
    clear_mon();
    read_txn(16'hFFFF, 2);
    check("t3_addr_q", 32'(exp_addr_q.size()), 32'd0);
    check("t3_byte_q", 32'(exp_byte_q.size()), 32'd0);
    check("t3_mem_addr", 32'(mem_addr), 32'h0001);

    // 4: unsupported opcode 0x9F
    clear_mon();
    cs_low();
    spi_byte(8'h9F);
    spi_byte(8'h00);
    spi_byte(8'h00);
    cs_high();
    check("t4_cmd_err", 32'(cmd_err_cnt), 32'd1);
    check("t4_oe", 32'(oe_seen), 32'd0);
    check("t4_extra_rd", 32'(extra_rd), 32'd0);

    // 5: abort after 12 address bits of ones, then READ 0x0020
    clear_mon();
    cs_low();
    spi_byte(8'h03);
    spi_byte(8'hFF);
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    cs_high();
    check("t5_abort_rd", 32'(extra_rd), 32'd0);
    check("t5_abort_mem_addr", 32'(mem_addr), 32'h0001);
    read_txn(16'h0020, 1);
    check("t5_addr_q", 32'(exp_addr_q.size()), 32'd0);
    check("t5_byte_q", 32'(exp_byte_q.size()), 32'd0);

    // 6: read status 0x05, 2 bytes
    clear_mon();
`ifdef RDSR_EN
    exp_byte_q.push_back(8'h00);
    exp_byte_q.push_back(8'h00);
`endif
    cs_low();
    spi_byte(8'h05);
`ifdef RDSR_EN
    rx_en = 1'b1;
`endif
    spi_byte(8'h00);
    spi_byte(8'h00);
    rx_en = 1'b0;
    cs_high();
`ifdef RDSR_EN
    check("t6_cmd_err", 32'(cmd_err_cnt), 32'd0);
    check("t6_oe", 32'(oe_seen), 32'd1);
    check("t6_byte_q", 32'(exp_byte_q.size()), 32'd0);
`else
    check("t6_cmd_err", 32'(cmd_err_cnt), 32'd1);
    check("t6_oe", 32'(oe_seen), 32'd0);
`endif
    check("t6_extra_rd", 32'(extra_rd), 32'd0);

    check("final_extra_rd", 32'(extra_rd), 32'd0);
    check("final_extra_bytes", 32'(extra_bytes), 32'd0);
    check("final_addr_q", 32'(exp_addr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
